// File: rtl/char_buffer_ctrl.sv
// Character buffer write controller: host writes (absolute or cursor addressed) and whole-buffer fill.
// Define CHAR_CTRL_BOUNDS_EN to drop out-of-range host writes/cursor loads and flag them on o_err.
module char_buffer_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4800
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    input  logic                  i_host_valid,
    output logic                  o_host_ready,
    input  logic                  i_host_mode,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_data,
    input  logic                  i_cur_load,
    input  logic                  i_fill_start,
    input  logic [DATA_WIDTH-1:0] i_fill_char,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_adr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [ADDR_WIDTH-1:0] o_cursor,
    output logic                  o_busy,
    output logic                  o_fill_done,
    output logic                  o_err
);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cursor, cursor_nxt;
    logic [ADDR_WIDTH-1:0]   fill_cnt, fill_cnt_nxt;
    logic [DATA_WIDTH-1:0]   fill_char, fill_char_nxt;
    logic                    wr_en_p1, wr_en_nxt;
    logic [ADDR_WIDTH-1:0]   wr_adr_p1, wr_adr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_p1, wr_data_nxt;
    logic                    fill_done_p1, fill_done_nxt;

    function automatic logic [ADDR_WIDTH-1:0] cursor_inc(input logic [ADDR_WIDTH-1:0] cur);
        return (cur >= LAST_ADR) ? '0 : cur + ADDR_WIDTH'(1);
    endfunction

`ifdef CHAR_CTRL_BOUNDS_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

    logic err_q, err_nxt;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] adr);
        return {1'b0, adr} < DEPTH_EXT;
    endfunction
`endif

    always_comb begin
        state_nxt     = state;
        cursor_nxt    = cursor;
        fill_cnt_nxt  = fill_cnt;
        fill_char_nxt = fill_char;
        wr_en_nxt     = 1'b0;
        wr_adr_nxt    = wr_adr_p1;
        wr_data_nxt   = wr_data_p1;
        fill_done_nxt = 1'b0;
`ifdef CHAR_CTRL_BOUNDS_EN
        err_nxt       = err_q;
`endif
        case (state)
            IDLE: begin
                if (i_host_valid) begin
                    wr_en_nxt   = 1'b1;
                    wr_adr_nxt  = i_host_mode ? cursor : i_host_addr;
                    wr_data_nxt = i_host_data;
                    if (i_host_mode)
                        cursor_nxt = cursor_inc(cursor);
`ifdef CHAR_CTRL_BOUNDS_EN
                    // Out-of-range absolute write: handshake still completes, nothing reaches the buffer
                    if (!i_host_mode && !in_range(i_host_addr)) begin
                        wr_en_nxt   = 1'b0;
                        wr_adr_nxt  = wr_adr_p1;
                        wr_data_nxt = wr_data_p1;
                        err_nxt     = 1'b1;
                    end
`endif
                end
                // Load overrides the increment from a simultaneous cursor-mode write
                if (i_cur_load) begin
                    cursor_nxt = i_host_addr;
`ifdef CHAR_CTRL_BOUNDS_EN
                    if (!in_range(i_host_addr)) begin
                        cursor_nxt = '0;
                        err_nxt    = 1'b1;
                    end
`endif
                end
                if (i_fill_start) begin
                    state_nxt     = FILL;
                    fill_char_nxt = i_fill_char;
                    fill_cnt_nxt  = '0;
                end
            end
            FILL: begin
                wr_en_nxt   = 1'b1;
                wr_adr_nxt  = fill_cnt;
                wr_data_nxt = fill_char;
                if (fill_cnt == LAST_ADR) begin
                    state_nxt     = IDLE;
                    fill_done_nxt = 1'b1;
                    cursor_nxt    = '0;
                    fill_cnt_nxt  = '0;
                end else begin
                    fill_cnt_nxt = fill_cnt + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    // p1: registered write port and control state
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cursor       <= '0;
            fill_cnt     <= '0;
            wr_en_p1     <= 1'b0;
            wr_adr_p1    <= '0;
            wr_data_p1   <= '0;
            fill_done_p1 <= 1'b0;
`ifdef CHAR_CTRL_BOUNDS_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cursor       <= cursor_nxt;
            fill_cnt     <= fill_cnt_nxt;
            wr_en_p1     <= wr_en_nxt;
            wr_adr_p1    <= wr_adr_nxt;
            wr_data_p1   <= wr_data_nxt;
            fill_done_p1 <= fill_done_nxt;
`ifdef CHAR_CTRL_BOUNDS_EN
            err_q        <= err_nxt;
`endif
        end
    end

    always_ff @(posedge i_sys_clk) begin
        fill_char <= fill_char_nxt;
    end

    assign o_host_ready = (state == IDLE);
    assign o_busy       = (state == FILL);
    assign o_wr_en      = wr_en_p1;
    assign o_wr_adr     = wr_adr_p1;
    assign o_wr_data    = wr_data_p1;
    assign o_fill_done  = fill_done_p1;
    assign o_cursor     = cursor;
`ifdef CHAR_CTRL_BOUNDS_EN
    assign o_err        = err_q;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_char_buffer_ctrl.sv
// Self-checking bench for char_buffer_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_char_buffer_ctrl;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 4800;

    logic          i_sys_clk = 1'b0;
    logic          i_rst_n;
    logic          i_host_valid;
    logic          o_host_ready;
    logic          i_host_mode;
    logic [AW-1:0] i_host_addr;
    logic [DW-1:0] i_host_data;
    logic          i_cur_load;
    logic          i_fill_start;
    logic [DW-1:0] i_fill_char;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_adr;
    logic [DW-1:0] o_wr_data;
    logic [AW-1:0] o_cursor;
    logic          o_busy;
    logic          o_fill_done;
    logic          o_err;

    char_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_sys_clk   (i_sys_clk),
        .i_rst_n     (i_rst_n),
        .i_host_valid(i_host_valid),
        .o_host_ready(o_host_ready),
        .i_host_mode (i_host_mode),
        .i_host_addr (i_host_addr),
        .i_host_data (i_host_data),
        .i_cur_load  (i_cur_load),
        .i_fill_start(i_fill_start),
        .i_fill_char (i_fill_char),
        .o_wr_en     (o_wr_en),
        .o_wr_adr    (o_wr_adr),
        .o_wr_data   (o_wr_data),
        .o_cursor    (o_cursor),
        .o_busy      (o_busy),
        .o_fill_done (o_fill_done),
        .o_err       (o_err)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int checks = 0;
    int passes = 0;

    // Behavioural model: remaining fill writes, cursor, sticky error, expected write port
    int            m_left = 0;
    int            m_cursor = 0;
    int            m_adr = 0;
    logic          m_en = 1'b0;
    logic          m_done = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_fill_char = '0;

    task automatic model_update();
        logic ok;
        if (!i_rst_n) begin
            m_left = 0; m_cursor = 0; m_err = 1'b0;
            m_en = 1'b0; m_adr = 0; m_data = '0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_en   = 1'b1;
            m_adr  = DEPTH - m_left;
            m_data = m_fill_char;
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_done) m_cursor = 0;
        end else begin
            m_en = 1'b0;
            m_done = 1'b0;
            if (i_host_valid) begin
                ok = 1'b1;
`ifdef CHAR_CTRL_BOUNDS_EN
                if (!i_host_mode && int'(i_host_addr) >= DEPTH) begin
                    ok = 1'b0;
                    m_err = 1'b1;
                end
`endif
                if (ok) begin
                    m_en   = 1'b1;
                    m_adr  = i_host_mode ? m_cursor : int'(i_host_addr);
                    m_data = i_host_data;
                end
                if (i_host_mode) m_cursor = (m_cursor >= DEPTH - 1) ? 0 : m_cursor + 1;
            end
            if (i_cur_load) begin
                m_cursor = int'(i_host_addr);
`ifdef CHAR_CTRL_BOUNDS_EN
                if (m_cursor >= DEPTH) begin
                    m_cursor = 0;
                    m_err = 1'b1;
                end
`endif
            end
            if (i_fill_start) begin
                m_left = DEPTH;
                m_fill_char = i_fill_char;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rst_n = 1'b1; i_host_valid = 1'b0; i_host_mode = 1'b0; i_host_addr = '0;
        i_host_data = '0; i_cur_load = 1'b0; i_fill_start = 1'b0; i_fill_char = '0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_host_valid = 1'b1; i_host_mode = 1'b0; i_host_addr = AW'($urandom_range(0, DEPTH-1));
        i_host_data = DW'($urandom); i_cur_load = 1'b1; i_fill_start = 1'b1; i_fill_char = DW'($urandom);
        step();
        step();
        checks++; if (o_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", o_wr_en); else passes++;
        checks++; if (o_wr_adr !== '0) $display("FAIL reset_wr_adr: got %0d want 0", o_wr_adr); else passes++;
        checks++; if (o_wr_data !== '0) $display("FAIL reset_wr_data: got %0h want 0", o_wr_data); else passes++;
        checks++; if (o_cursor !== '0) $display("FAIL reset_cursor: got %0d want 0", o_cursor); else passes++;
        checks++; if (o_fill_done !== 1'b0 || o_err !== 1'b0) $display("FAIL reset_done_err: got %0b%0b want 00", o_fill_done, o_err); else passes++;
        checks++; if (o_busy !== 1'b0 || o_host_ready !== 1'b1) $display("FAIL reset_state: busy=%0b ready=%0b want 0/1", o_busy, o_host_ready); else passes++;
        idle_inputs();
        step();
    endtask

    task automatic test_abs_write();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        i_host_valid = 1'b1; i_host_mode = 1'b0; i_host_addr = AW'(100); i_host_data = 8'h41;
        step();
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(100) || o_wr_data !== 8'h41)
            $display("FAIL abs_write: got en=%0b adr=%0d data=%0h want 1/100/41", o_wr_en, o_wr_adr, o_wr_data);
        else passes++;
        idle_inputs();
        step();
        checks++; if (o_wr_en !== 1'b0) $display("FAIL abs_no_write: got en=%0b want 0", o_wr_en); else passes++;
        // Back-to-back absolute writes, one per cycle
        for (int i = 0; i < 8; i++) begin
            a = AW'($urandom_range(0, DEPTH-1));
            d = DW'($urandom);
            i_host_valid = 1'b1; i_host_mode = 1'b0; i_host_addr = a; i_host_data = d;
            step();
            checks++;
            if (o_wr_en !== 1'b1 || o_wr_adr !== a || o_wr_data !== d)
                $display("FAIL abs_b2b: got en=%0b adr=%0d data=%0h want 1/%0d/%0h", o_wr_en, o_wr_adr, o_wr_data, a, d);
            else passes++;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_cursor();
        int            exp_adr [3];
        logic [DW-1:0] chars [3];
        exp_adr = '{4798, 4799, 0};
        chars   = '{8'h41, 8'h42, 8'h43};
        i_cur_load = 1'b1; i_host_addr = AW'(4798);
        step();
        checks++; if (o_cursor !== AW'(4798)) $display("FAIL cur_load: got %0d want 4798", o_cursor); else passes++;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            i_host_valid = 1'b1; i_host_mode = 1'b1; i_host_addr = AW'($urandom_range(0, DEPTH-1)); i_host_data = chars[i];
            step();
            checks++;
            if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(exp_adr[i]) || o_wr_data !== chars[i])
                $display("FAIL cur_write%0d: got en=%0b adr=%0d data=%0h want 1/%0d/%0h", i, o_wr_en, o_wr_adr, o_wr_data, exp_adr[i], chars[i]);
            else passes++;
        end
        checks++; if (o_cursor !== AW'(1)) $display("FAIL cur_after_wrap: got %0d want 1", o_cursor); else passes++;
        // Cursor write coinciding with a load: write at old cursor, load wins
        i_host_valid = 1'b1; i_host_mode = 1'b1; i_host_addr = AW'(50); i_host_data = 8'h44; i_cur_load = 1'b1;
        step();
        checks++;
        if (o_wr_adr !== AW'(1) || o_wr_en !== 1'b1 || o_cursor !== AW'(50))
            $display("FAIL cur_load_collide: got adr=%0d en=%0b cursor=%0d want 1/1/50", o_wr_adr, o_wr_en, o_cursor);
        else passes++;
        idle_inputs();
        step();
    endtask

    task automatic test_fill();
        int fill_good = 0;
        int done_cnt  = 0;
        i_fill_start = 1'b1; i_fill_char = 8'h20; i_host_valid = 1'b1; i_host_mode = 1'b0;
        i_host_addr = AW'(123); i_host_data = 8'h77;
        step();
        // Cycle N+1: the coinciding host write lands, fill has begun
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(123) || o_busy !== 1'b1 || o_host_ready !== 1'b0)
            $display("FAIL fill_entry: got en=%0b adr=%0d busy=%0b ready=%0b want 1/123/1/0", o_wr_en, o_wr_adr, o_busy, o_host_ready);
        else passes++;
        idle_inputs();
        for (int t = 1; t <= 4803; t++) begin
            if (o_fill_done === 1'b1) done_cnt++;
            if (t >= 2 && t <= DEPTH + 1 && o_wr_en === 1'b1 && o_wr_adr === AW'(t - 2) && o_wr_data === 8'h20)
                fill_good++;
            if (t == 101) begin
                checks++;
                if (o_cursor !== AW'(m_cursor) || o_wr_adr !== AW'(99))
                    $display("FAIL fill_ignore: got cursor=%0d adr=%0d want %0d/99", o_cursor, o_wr_adr, m_cursor);
                else passes++;
            end
            if (t == DEPTH + 1) begin
                checks++;
                if (o_fill_done !== 1'b1 || o_host_ready !== 1'b1 || o_cursor !== '0 || o_wr_adr !== AW'(DEPTH-1))
                    $display("FAIL fill_end: got done=%0b ready=%0b cursor=%0d adr=%0d want 1/1/0/%0d", o_fill_done, o_host_ready, o_cursor, o_wr_adr, DEPTH-1);
                else passes++;
            end
            if (t == DEPTH + 2) begin
                checks++;
                if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(777) || o_wr_data !== 8'h5A)
                    $display("FAIL fill_stalled_host: got en=%0b adr=%0d data=%0h want 1/777/5a", o_wr_en, o_wr_adr, o_wr_data);
                else passes++;
            end
            if (t == DEPTH + 3) begin
                checks++; if (o_wr_en !== 1'b0) $display("FAIL fill_host_once: got en=%0b want 0", o_wr_en); else passes++;
            end
            i_host_valid = (t >= 5 && t <= DEPTH + 1);
            i_host_mode = 1'b0; i_host_addr = AW'(777); i_host_data = 8'h5A;
            i_cur_load   = (t == 100);
            i_fill_start = (t == 100);
            i_fill_char  = 8'hEE;
            if (t == 100) i_host_addr = AW'(33);
            step();
        end
        checks++; if (fill_good !== DEPTH) $display("FAIL fill_writes: got %0d want %0d", fill_good, DEPTH); else passes++;
        checks++; if (done_cnt !== 1) $display("FAIL fill_done_pulses: got %0d want 1", done_cnt); else passes++;
        idle_inputs();
    endtask

    task automatic test_fill_reset();
        int stray = 0;
        i_fill_start = 1'b1; i_fill_char = 8'h2E;
        step();
        idle_inputs();
        for (int t = 1; t < 2002; t++) step();
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(2000))
            $display("FAIL fillrst_pos: got en=%0b adr=%0d want 1/2000", o_wr_en, o_wr_adr);
        else passes++;
        i_rst_n = 1'b0;
        step();
        checks++;
        if (o_wr_en !== 1'b0 || o_fill_done !== 1'b0 || o_host_ready !== 1'b1 || o_busy !== 1'b0)
            $display("FAIL fillrst_abort: got en=%0b done=%0b ready=%0b busy=%0b want 0/0/1/0", o_wr_en, o_fill_done, o_host_ready, o_busy);
        else passes++;
        i_rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (o_wr_en !== 1'b0 || o_fill_done !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) $display("FAIL fillrst_quiet: got %0d active cycles want 0", stray); else passes++;
    endtask

    task automatic test_bounds();
        checks++; if (o_host_ready !== 1'b1) $display("FAIL bounds_ready: got %0b want 1", o_host_ready); else passes++;
        i_host_valid = 1'b1; i_host_mode = 1'b0; i_host_addr = AW'(5000); i_host_data = 8'h33;
        step();
        idle_inputs();
`ifdef CHAR_CTRL_BOUNDS_EN
        checks++;
        if (o_wr_en !== 1'b0 || o_err !== 1'b1)
            $display("FAIL bounds_drop: got en=%0b err=%0b want 0/1", o_wr_en, o_err);
        else passes++;
        step(); step();
        i_host_valid = 1'b1; i_host_addr = AW'(10); i_host_data = 8'h11;
        step();
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(10) || o_err !== 1'b1)
            $display("FAIL bounds_sticky: got en=%0b adr=%0d err=%0b want 1/10/1", o_wr_en, o_wr_adr, o_err);
        else passes++;
        idle_inputs();
        i_cur_load = 1'b1; i_host_addr = AW'(6000);
        step();
        checks++; if (o_cursor !== '0) $display("FAIL bounds_curload: got %0d want 0", o_cursor); else passes++;
`else
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_adr !== AW'(5000) || o_err !== 1'b0)
            $display("FAIL bounds_pass: got en=%0b adr=%0d err=%0b want 1/5000/0", o_wr_en, o_wr_adr, o_err);
        else passes++;
`endif
        idle_inputs();
        i_rst_n = 1'b0;
        step();
        checks++; if (o_err !== 1'b0) $display("FAIL bounds_err_clear: got %0b want 0", o_err); else passes++;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            i_rst_n      = ($urandom_range(0, 299) != 0);
            i_host_valid = 1'($urandom_range(0, 1));
            i_host_mode  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)      i_host_addr = AW'($urandom_range(0, 8191));
            else if ($urandom_range(0, 3) == 0) i_host_addr = AW'($urandom_range(DEPTH-4, DEPTH-1));
            else                                i_host_addr = AW'($urandom_range(0, DEPTH-1));
            i_host_data  = DW'($urandom);
            i_cur_load   = ($urandom_range(0, 9) == 0);
            i_fill_start = ($urandom_range(0, 1499) == 0);
            i_fill_char  = DW'($urandom);
            step();
            checks++;
            if (o_wr_en !== m_en || o_fill_done !== m_done || o_err !== m_err || o_cursor !== AW'(m_cursor) ||
                o_busy !== (m_left > 0) || o_host_ready !== (m_left == 0) ||
                (m_en && (o_wr_adr !== AW'(m_adr) || o_wr_data !== m_data)))
                $display("FAIL random@%0d: got en=%0b adr=%0d data=%0h done=%0b err=%0b cur=%0d busy=%0b want en=%0b adr=%0d data=%0h done=%0b err=%0b cur=%0d busy=%0b",
                         c, o_wr_en, o_wr_adr, o_wr_data, o_fill_done, o_err, o_cursor, o_busy,
                         m_en, m_adr, m_data, m_done, m_err, m_cursor, (m_left > 0));
            else passes++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_abs_write();
        test_cursor();
        test_fill();
        test_fill_reset();
        test_bounds();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/char_buffer_ctrl.md
CHAR_BUFFER_CTRL -- requirements
Module: char_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: character buffer address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: character code width.
REQ-003 SHALL have parameter DEPTH, default 4800: number of valid character cells.
REQ-004 SHALL have port i_sys_clk  input  1  sole clock; one clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_host_valid  input  1  host write request.
REQ-007 SHALL have port o_host_ready  output  1  host request accepted when valid&&ready.
REQ-008 SHALL have port i_host_mode  input  1  0 = absolute address, 1 = cursor address.
REQ-009 SHALL have port i_host_addr  input  ADDR_WIDTH  absolute write address / cursor load value.
REQ-010 SHALL have port i_host_data  input  DATA_WIDTH  character to write.
REQ-011 SHALL have port i_cur_load  input  1  load cursor from i_host_addr.
REQ-012 SHALL have port i_fill_start  input  1  start whole-buffer fill.
REQ-013 SHALL have port i_fill_char  input  DATA_WIDTH  fill character.
REQ-014 SHALL have ports o_wr_en (1), o_wr_adr (ADDR_WIDTH), o_wr_data (DATA_WIDTH), all outputs: character buffer write port.
REQ-015 SHALL have ports o_cursor (output, ADDR_WIDTH), o_busy (output, 1), o_fill_done (output, 1), o_err (output, 1).

Function
REQ-016 SHALL implement states IDLE and FILL; o_host_ready = 1 iff state is IDLE; o_busy = 1 iff state is FILL.
REQ-017 SHALL register all write-port outputs: a host transfer in cycle N drives o_wr_en=1 with its address/data in cycle N+1; o_wr_en=0 in every cycle without a write.
REQ-018 SHALL use i_host_addr as the write address when i_host_mode=0 and o_cursor when i_host_mode=1.
REQ-019 SHALL advance the cursor by 1 after each cursor-mode transfer, wrapping to 0 when the cursor is >= DEPTH-1.
REQ-020 SHALL load the cursor from i_host_addr on i_cur_load in IDLE; simultaneous cursor-mode transfer writes at the old cursor, and the load wins over the increment.
REQ-021 SHALL ignore i_cur_load in FILL.
REQ-022 SHALL, on i_fill_start in IDLE at cycle N, latch i_fill_char and enter FILL at N+1.
REQ-023 SHALL ignore i_fill_start while in FILL.
REQ-024 SHALL, in FILL, issue one write per cycle at addresses 0..DEPTH-1 ascending, so o_wr_en is high for cycles N+2..N+DEPTH+1.
REQ-025 SHALL return to IDLE at N+DEPTH+1 after issuing address DEPTH-1, and reset the cursor to 0 at the same time.
REQ-026 SHALL pulse o_fill_done for exactly one cycle, coincident with the o_wr_en cycle for address DEPTH-1.
REQ-027 SHALL, when i_host_valid and i_fill_start coincide in IDLE, accept the host write (output at N+1) and then start the fill, which overwrites it.
REQ-028 SHALL keep host data unlost: a request held during FILL stalls with o_host_ready=0 and completes on the first IDLE cycle.

Reset
REQ-029 SHALL, on i_rst_n=0 at a clock edge, force state IDLE, o_wr_en=0, o_wr_adr=0, o_wr_data=0, cursor=0, fill counter=0, o_fill_done=0, o_err=0.
REQ-030 SHALL, if reset occurs mid-fill, abort the fill immediately with no further writes and no o_fill_done pulse.

Configuration
REQ-031 SHALL, with macro CHAR_CTRL_BOUNDS_EN defined, complete the handshake for absolute writes with i_host_addr >= DEPTH, issue no write, and set sticky o_err until reset.
REQ-032 SHALL, with CHAR_CTRL_BOUNDS_EN defined, load cursor 0 on a cursor load of a value >= DEPTH and set o_err.
REQ-033 SHALL, without CHAR_CTRL_BOUNDS_EN, pass all addresses through unchecked, with o_err tied to 0.

Verification
REQ-034 SHALL cover: reset, then absolute write addr=100 data=0x41 -> cycle N+1 o_wr_en=1, o_wr_adr=100, o_wr_data=0x41.
REQ-035 SHALL cover: cur_load 4798, then three cursor-mode writes 'A','B','C' -> writes at 4798, 4799, 0; o_cursor=1.
REQ-036 SHALL cover: fill_start with char 0x20 at N -> 4800 consecutive writes 0..4799 at N+2..N+4801, o_fill_done only at N+4801, o_host_ready=1 at N+4801.
REQ-037 SHALL cover: host valid held from N+5 during fill -> accepted at N+4801, write at N+4802.
REQ-038 SHALL cover: reset asserted at fill address 2000 -> o_wr_en=0 next cycle, no o_fill_done pulse, o_host_ready=1.
REQ-039 SHALL cover, with CHAR_CTRL_BOUNDS_EN: absolute write addr=5000 -> no o_wr_en, o_err=1 sticky; without the macro -> write issued at 5000, o_err=0.
